// File: rtl/uart_tx_sched_if.sv
// Requester and FIFO write-side signal bundle for uart_tx_sched.
// The producer/FIFO environment uses the master modport, the scheduler the slave modport.
interface uart_tx_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_rd_done;

  // Producers and the FIFO read side: offer bytes, report pops, observe writes.
  modport master (
    output req_valid, req_data, req_last, fifo_rd_done,
    input  req_ready, fifo_wr_en, fifo_din
  );

  // Scheduler: accepts bytes and owns the FIFO write port.
  modport slave (
    input  req_valid, req_data, req_last, fifo_rd_done,
    output req_ready, fifo_wr_en, fifo_din
  );

endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing the UART TX FIFO write port between NUM_REQ
// byte-stream producers. A grant is held for a whole packet (until req_last),
// and every write is gated by a credit counter that mirrors free FIFO slots,
// including writes still in flight, so the FIFO is never written while full.
module uart_tx_sched #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int CRED_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_sched_if.slave    bus,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy,
  output logic [CRED_W-1:0] credits,
  output logic              cred_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;

  logic                  arb_found;
  logic [ID_W-1:0]       arb_winner;

  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  xfer_last;
  logic                  xfer;
  logic                  cred_full;
  logic                  pop_eff;

  // Requester index base+off, wrapped modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_W-1:0];
  endfunction

  // Round-robin pick: first valid requester at or after rr_ptr, scanning with wrap.
  always_comb begin
    // NOTE: every combinational output is given a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    arb_found  = 1'b0;
    arb_winner = rr_ptr;
    // Scan from the far end so the nearest valid index is the one left standing.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_inc(rr_ptr, k)]) begin
        arb_found  = 1'b1;
        arb_winner = wrap_inc(rr_ptr, k);
      end
    end
  end

  // Accept decode and data/last mux for the granted requester.
  always_comb begin
    ready     = '0;
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        ready[i]  = (state == XFER) && (credits != '0);
        xfer_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        xfer_last = bus.req_last[i];
      end
    end
  end

  assign bus.req_ready = ready;
  assign xfer          = |(ready & bus.req_valid);
  assign cred_full     = (credits == CRED_MAX);
  // A pop reported while every slot is already free is bogus and must not count.
  assign pop_eff       = bus.fifo_rd_done && !cred_full;

  // Control FSM: arbitration, packet lock, round-robin pointer and busy flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            grant_id <= arb_winner;
            busy     <= 1'b1;
            state    <= XFER;
          end else begin
            // Valids dropped between IDLE and ARB.
            state <= IDLE;
          end
        end
        XFER: begin
          // Stalls (valid low or no credits) simply hold here with the grant locked.
          if (xfer && xfer_last) begin
            rr_ptr <= wrap_inc(grant_id, 1);
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered FIFO write port: one strobe the cycle after each accepted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= '0;
    end else begin
      bus.fifo_wr_en <= xfer;
      if (xfer) bus.fifo_din <= xfer_data;
    end
  end

  // Credit counter: free FIFO slots, decremented at accept time so in-flight
  // writes are already accounted for; sticky error on pops at full credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits  <= CRED_MAX;
      cred_err <= 1'b0;
    end else begin
      // xfer needs credits != 0 and pop_eff needs credits != max, so no wrap.
      unique case ({pop_eff, xfer})
        2'b10:   credits <= credits + CRED_W'(1);
        2'b01:   credits <= credits - CRED_W'(1);
        default: credits <= credits;
      endcase
      if (bus.fifo_rd_done && cred_full) cred_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a packet-level reference model is
// compared against the DUT every cycle, and directed scenarios add literal
// expectations for ordering, latency, credit exhaustion and reset behaviour.
module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int DEPTH   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant_id;
  logic       busy;
  logic [4:0] credits;
  logic       cred_err;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  uart_tx_sched #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .grant_id(grant_id),
    .busy    (busy),
    .credits (credits),
    .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  bit         m_owned = 1'b0;   // a requester currently holds the port
  bit         m_arb   = 1'b0;   // the one-cycle arbitration slot is pending
  int         m_gid   = 0;
  int         m_ptr   = 0;
  int         m_cred  = DEPTH;
  bit         m_err   = 1'b0;
  bit         m_wr    = 1'b0;
  logic [7:0] m_din   = 8'h00;
  int         mg, midx;
  bit         mxf, mpop, mfound;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owned = 1'b0; m_arb = 1'b0; m_gid = 0; m_ptr = 0;
      m_cred  = DEPTH; m_err = 1'b0; m_wr = 1'b0; m_din = 8'h00;
    end else begin
      mg   = m_gid;
      mxf  = m_owned && (m_cred > 0) && (bus.req_valid[mg] === 1'b1);
      mpop = (bus.fifo_rd_done === 1'b1) && (m_cred < DEPTH);
      if (bus.fifo_rd_done === 1'b1 && m_cred == DEPTH) m_err = 1'b1;
      m_cred = m_cred + (mpop ? 1 : 0) - (mxf ? 1 : 0);
      m_wr   = mxf;
      if (mxf) m_din = bus.req_data[mg*DW +: DW];
      if (m_owned) begin
        if (mxf && bus.req_last[mg] === 1'b1) begin
          m_owned = 1'b0;
          m_ptr   = (mg + 1) % NUM_REQ;
        end
      end else if (m_arb) begin
        m_arb  = 1'b0;
        mfound = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          midx = (m_ptr + k) % NUM_REQ;
          if (!mfound && bus.req_valid[midx] === 1'b1) begin
            mfound = 1'b1;
            m_gid  = midx;
          end
        end
        m_owned = mfound;
      end else if (|bus.req_valid) begin
        m_arb = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and DUT logs ----------------
  int         cyc = 0;
  logic [7:0] wlog [256];
  int         wcnt = 0;
  int         glog_id  [64];
  int         glog_cyc [64];
  int         gcnt = 0;
  logic       busy_d = 1'b0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] er;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) er[i] = m_owned && (m_gid == i) && (m_cred > 0);
    check("req_ready",  32'(bus.req_ready),  32'(er));
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr));
    check("fifo_din",   32'(bus.fifo_din),   32'(m_din));
    check("grant_id",   32'(grant_id),       m_gid);
    check("busy",       32'(busy),           32'(m_owned));
    check("credits",    32'(credits),        m_cred);
    check("cred_err",   32'(cred_err),       32'(m_err));
    if (bus.fifo_wr_en === 1'b1 && wcnt < 256) begin
      wlog[wcnt] = bus.fifo_din;
      wcnt++;
    end
    if (busy === 1'b1 && busy_d !== 1'b1 && gcnt < 64) begin
      glog_id[gcnt]  = int'(grant_id);
      glog_cyc[gcnt] = cyc;
      gcnt++;
    end
    busy_d = busy;
  end

  // ---------------- stimulus: per-requester packet queues ----------------
  logic [8:0] pq [NUM_REQ][64];   // {last, data}
  int         ph [NUM_REQ];
  int         pt [NUM_REQ];
  bit         hold [NUM_REQ];

  task automatic push(input int id, input logic [7:0] d, input bit last);
    pq[id][pt[id]] = {last, d};
    pt[id]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ph[i] < pt[i] && !hold[i]) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*DW +: DW]  = pq[i][ph[i]][7:0];
        bus.req_last[i]           = pq[i][ph[i]][8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (ph[i] < pt[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: handshakes are decided by the values stable before the edge;
  // inputs are re-driven just after the following falling edge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) ph[i]++;
    bus.fifo_rd_done = 1'b0;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((pending() || busy === 1'b1) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(pending() || busy !== 1'b0), 0);
  endtask

  task automatic wait_sent(input int id, input int n, input int budget);
    int c;
    c = 0;
    while (ph[id] < n && c < budget) begin
      step();
      c++;
    end
    check("sent_timeout", 32'(ph[id] >= n), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ph[i] = 0; pt[i] = 0; hold[i] = 1'b0;
    end
    bus.fifo_rd_done = 1'b0;
    drive();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // ---------------- directed scenarios ----------------
  int         w0, g0, w_rst;
  int         exp_g [5]  = '{0, 1, 2, 3, 0};
  logic [7:0] exp_w2 [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11};
  logic [7:0] exp_w3 [5] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0};

  initial begin
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.req_last     = '0;
    bus.fifo_rd_done = 1'b0;
    do_reset();

    // Reset values.
    check("rst_credits",  32'(credits),        16);
    check("rst_busy",     32'(busy),           0);
    check("rst_grant",    32'(grant_id),       0);
    check("rst_wr_en",    32'(bus.fifo_wr_en), 0);
    check("rst_din",      32'(bus.fifo_din),   0);
    check("rst_cred_err", 32'(cred_err),       0);

    // Single requester: req 2 sends A1 A2 A3.
    w0 = wcnt;
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    drive();
    step();
    check("t1_arb_ready", 32'(bus.req_ready), 0);
    check("t1_arb_busy",  32'(busy),          0);
    step();
    check("t1_ready_3rd", 32'(bus.req_ready), 32'b0100);
    run_until_idle(20);
    check("t1_wcount",  wcnt - w0,          3);
    check("t1_w0",      32'(wlog[w0]),      32'hA1);
    check("t1_w1",      32'(wlog[w0 + 1]),  32'hA2);
    check("t1_w2",      32'(wlog[w0 + 2]),  32'hA3);
    check("t1_credits", 32'(credits),       13);
    check("t1_grant",   32'(grant_id),      2);
    check("t1_busy",    32'(busy),          0);
    check("t1_m_ptr",   m_ptr,              3);

    // Round-robin: all four valid with 1-byte packets, req 0 has two.
    do_reset();
    w0 = wcnt;
    g0 = gcnt;
    push(0, 8'h10, 1'b1);
    push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1);
    push(3, 8'h40, 1'b1);
    drive();
    run_until_idle(60);
    check("t2_gcount", gcnt - g0, 5);
    for (int k = 0; k < 5; k++) begin
      check("t2_grant_order", glog_id[g0 + k], exp_g[k]);
      check("t2_write_order", 32'(wlog[w0 + k]), 32'(exp_w2[k]));
    end
    for (int k = 0; k < 4; k++)
      check("t2_grant_spacing", glog_cyc[g0 + k + 1] - glog_cyc[g0 + k], 3);
    check("t2_m_ptr", m_ptr, 1);

    // Packet lock: req 1 owns the port (pointer is 1) while req 0 waits.
    w0 = wcnt;
    push(1, 8'hB0, 1'b0);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    push(0, 8'hC0, 1'b1);
    drive();
    wait_sent(1, 2, 20);
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_busy",     32'(busy),             1);
      check("t3_grant",    32'(grant_id),         1);
      check("t3_ready0",   32'(bus.req_ready[0]), 0);
      check("t3_ready1",   32'(bus.req_ready[1]), 1);
      check("t3_no_write", 32'(bus.fifo_wr_en),   0);
    end
    hold[1] = 1'b0;
    drive();
    run_until_idle(30);
    check("t3_wcount", wcnt - w0, 5);
    for (int k = 0; k < 5; k++) check("t3_write_order", 32'(wlog[w0 + k]), 32'(exp_w3[k]));

    // Credit exhaustion: 20-byte packet from req 0 with no pops.
    do_reset();
    w0 = wcnt;
    for (int k = 0; k < 20; k++) push(0, 8'(8'h50 + k), (k == 19));
    drive();
    repeat (24) step();
    check("t4_wcount16", wcnt - w0,         16);
    check("t4_cred0",    32'(credits),      0);
    check("t4_ready0",   32'(bus.req_ready), 0);
    check("t4_busy",     32'(busy),         1);
    bus.fifo_rd_done = 1'b1;
    step();
    check("t4_pop_cred",  32'(credits),        1);
    check("t4_pop_ready", 32'(bus.req_ready),  32'b0001);
    check("t4_pop_nowr",  32'(bus.fifo_wr_en), 0);
    step();
    check("t4_one_more_wr", 32'(bus.fifo_wr_en), 1);
    check("t4_one_more_c",  32'(credits),        0);
    check("t4_wcount17",    wcnt - w0,           17);
    step();
    check("t4_wcount17b",   wcnt - w0,           17);
    check("t4_ready_again", 32'(bus.req_ready),  0);
    bus.fifo_rd_done = 1'b1;
    step();
    bus.fifo_rd_done = 1'b1;
    step();
    check("t4_coinc_cred", 32'(credits),        1);
    check("t4_coinc_wr",   32'(bus.fifo_wr_en), 1);
    check("t4_wcount18",   wcnt - w0,           18);
    step();
    check("t4_cred_drain", 32'(credits), 0);
    bus.fifo_rd_done = 1'b1;
    step();
    step();
    check("t4_wcount20", wcnt - w0,    20);
    check("t4_done",     32'(busy),    0);
    check("t4_cred_end", 32'(credits), 0);
    check("t4_last_din", 32'(bus.fifo_din), 32'h63);

    // Over-pop at full credits, then reset mid-packet.
    do_reset();
    bus.fifo_rd_done = 1'b1;
    step();
    check("t5_cred_full", 32'(credits),  16);
    check("t5_err",       32'(cred_err), 1);
    step();
    step();
    check("t5_err_sticky", 32'(cred_err), 1);
    for (int k = 0; k < 5; k++) push(0, 8'(8'hE0 + k), (k == 4));
    drive();
    wait_sent(0, 2, 20);
    w_rst = wcnt;
    reset = 1'b1;
    #1;
    check("t5_rst_wr_en",  32'(bus.fifo_wr_en), 0);
    check("t5_rst_cred",   32'(credits),        16);
    check("t5_rst_err",    32'(cred_err),       0);
    check("t5_rst_busy",   32'(busy),           0);
    check("t5_rst_ready",  32'(bus.req_ready),  0);
    check("t5_rst_grant",  32'(grant_id),       0);
    check("t5_rst_din",    32'(bus.fifo_din),   0);
    for (int i = 0; i < NUM_REQ; i++) begin
      ph[i] = 0; pt[i] = 0;
    end
    drive();
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    check("t5_no_write_after_rst", wcnt - w_rst, 0);
    check("t5_idle_cred",          32'(credits), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single write port of the UART transmit FIFO between `NUM_REQ` byte-stream producers. It grants one requester at a time and holds the grant until that requester's packet completes, marked by `req_last`. It gates every write with an internal credit counter that mirrors FIFO occupancy, so the FIFO never sees a write while it is full. It sits between the producers (command/status/debug sources) and the `fifo` write side, and the UART TX engine drains the FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width; must match the FIFO.
- `FIFO_DEPTH`, 16: depth of the downstream FIFO; sets the initial and maximum credit count.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i's byte is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  qualifies the current byte as the final byte of the packet.
- `req_ready`  out  NUM_REQ  per-requester accept; combinational.
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_din`  out  DATA_WIDTH  registered write data.
- `fifo_rd_done`  in  1  one-cycle pulse per byte actually popped from the FIFO (consumer's `rd_en && !empty`).
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `busy`  out  1  high while in state XFER.
- `credits`  out  clog2(FIFO_DEPTH)+1  free FIFO slots.
- `cred_err`  out  1  sticky: `fifo_rd_done` arrived while credits == FIFO_DEPTH.

## Operation
- **States:**
  - IDLE: no grant.
  - ARB: one cycle; latches the winner.
  - XFER: moves the granted packet.
- **IDLE → ARB** when any `req_valid` bit is high.
- **ARB selection:** scan starts at `rr_ptr` and wraps modulo NUM_REQ. The first index with valid high wins; `grant_id` is set to it.
  - If no valid bit is high in ARB (valids dropped), return to IDLE.
- **Handshake:** `req_ready[i] = (state == XFER) && (grant_id == i) && (credits != 0)`. All other ready bits are 0.
  - A byte transfers on a cycle where `req_valid[g] && req_ready[g]`.
- **On a transfer:**
  - Next cycle: `fifo_wr_en` = 1 and `fifo_din` = the byte. In all other cycles `fifo_wr_en` = 0 and `fifo_din` holds its last value.
  - credits decrements in the same edge.
- **XFER → IDLE** on a transfer with `req_last[g]` = 1.
  - `rr_ptr` becomes (g + 1) mod NUM_REQ.
  - `grant_id` keeps g.
- **Stalls:**
  - If the granted requester drops valid mid-packet, stay in XFER indefinitely. No other requester is served.
  - If credits == 0, ready is low and the FSM holds in XFER.
- **Credit update, per edge:** `credits += fifo_rd_done_eff − xfer`.
  - `fifo_rd_done_eff` = `fifo_rd_done && credits != FIFO_DEPTH`.
  - A simultaneous pop and transfer leaves credits unchanged.
  - A pop at full credits is ignored and sets `cred_err`; only reset clears it.
- **Credit range:** 0..FIFO_DEPTH. The arithmetic never wraps.
- **Reset values:**
  - State IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - `fifo_wr_en` = 0, `fifo_din` = 0.
  - `credits` = FIFO_DEPTH, `busy` = 0, `cred_err` = 0.
  - `req_ready` = 0 (follows from the state).
- **Reset mid-packet:** the packet is abandoned and no `fifo_wr_en` is issued after reset asserts. Requesters must restart the packet.

## Timing
- Latency from first `req_valid` (in IDLE) to first possible transfer: 2 cycles (IDLE→ARB, ARB→XFER). `req_ready` is high in the 3rd cycle.
- Transfer to `fifo_wr_en`: 1 cycle.
- Throughput in XFER: 1 byte per cycle while credits > 0.
- Packet to next packet: 2 idle cycles (return to IDLE, then ARB) before the next transfer.
- A `fifo_rd_done` in cycle n makes `credits` nonzero in cycle n+1, and ready can rise in n+1.
- `credits` accounts for writes still in flight. The FIFO's registered `full` flag is never used.

## Test plan
- **Single requester:** req 2 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3) with no pops. Expect `fifo_wr_en` pulses carrying those bytes in order, credits 16→13, `rr_ptr` = 3, `grant_id` = 2, back to IDLE.
- **Round-robin:** all 4 requesters hold valid with 1-byte packets. Expect grant order 0, 1, 2, 3, 0, each packet 3 cycles apart.
- **Packet lock:** req 1 sends a 4-byte packet while req 0 is valid throughout. Expect no `req_ready[0]` until req 1's last byte is accepted. If req 1 drops valid for 5 cycles mid-packet, the FSM stays in XFER with `grant_id` = 1.
- **Credit exhaustion:** no pops, req 0 streams 20 bytes. Expect exactly 16 writes, then credits = 0 and `req_ready[0]` = 0.
  - One `fifo_rd_done` pulse → exactly one more write one cycle later.
  - `fifo_rd_done` coincident with a transfer leaves credits unchanged.
- **Over-pop and reset:** `fifo_rd_done` with credits = 16 → credits stays 16 and `cred_err` = 1.
  - Assert reset mid-packet after 2 of 5 bytes → all outputs return to reset values immediately (`cred_err` = 0, credits = 16) and no further writes occur.
